// File: rtl/pre_load_ctrl_pkg.sv
// Shared definitions for the weight pre-load controller: tile geometry,
// port widths and the controller state encoding.
package pre_load_ctrl_pkg;

  localparam int PL_N_WEIGHTS    = 64;  // weights per tile (8 columns x 8 rows)
  localparam int PL_COL_SIZE     = 8;   // weights per column
  localparam int PL_COMP_PER_COL = 3;   // compensation entries allowed per column
  localparam int PL_ADDR_W       = 6;   // weight memory address width
  localparam int PL_CNT_W        = 5;   // comp_cnt width (0..24)

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pre_load_ctrl_comp_detect.sv
// Compensation classifier: a weight needs a compensation entry when it does
// not fit in 5-bit signed range (-16..15), i.e. its top nibble is not a pure
// sign extension (all zeros or all ones).
module pl_comp_detect (
  input  logic [3:0] w_nib,
  output logic       is_comp
);

  // Purely combinational decode of the upper nibble.
  always_comb begin
    is_comp = (w_nib != 4'h0) && (w_nib != 4'hF);
  end

endmodule

// File: rtl/pre_load_ctrl.sv
// Weight pre-load controller: accepts one tile of weights from a valid/ready
// source, forwards each weight with its address to the pre-load unit one
// cycle later, and tracks how many weights need compensation entries.
module pre_load_ctrl
  import pre_load_ctrl_pkg::*;
#(
  parameter int N_WEIGHTS    = PL_N_WEIGHTS,
  parameter int COL_SIZE     = PL_COL_SIZE,
  parameter int COMP_PER_COL = PL_COMP_PER_COL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 w_valid,
  input  logic [7:0]           w_data,
  output logic                 w_ready,
  output logic [7:0]           pl_weight,
  output logic [PL_ADDR_W-1:0] pl_addr,
  output logic                 pl_we,
  output logic                 pl_done,
  output logic                 busy,
  output logic [PL_CNT_W-1:0]  comp_cnt,
  output logic                 comp_ovf
);

  localparam int COMP_MAX = COMP_PER_COL * (N_WEIGHTS / COL_SIZE);
  localparam int COLCNT_W = $clog2(COL_SIZE + 1);

  localparam logic [PL_ADDR_W-1:0] LAST_BEAT = PL_ADDR_W'(N_WEIGHTS - 1);
  localparam logic [PL_ADDR_W-1:0] COL_LEN   = PL_ADDR_W'(COL_SIZE);
  localparam logic [PL_CNT_W-1:0]  CNT_SAT   = PL_CNT_W'(COMP_MAX);
  localparam logic [COLCNT_W-1:0]  COL_LIMIT = COLCNT_W'(COMP_PER_COL);

  state_e               state_q, state_d;
  logic [PL_ADDR_W-1:0] beat_q, beat_d;
  logic [COLCNT_W-1:0]  col_comp_q, col_comp_d;
  logic [PL_CNT_W-1:0]  comp_cnt_q, comp_cnt_d;
  logic                 comp_ovf_q, comp_ovf_d;
  logic                 pl_we_q, pl_we_d;
  logic [7:0]           pl_weight_q, pl_weight_d;
  logic [PL_ADDR_W-1:0] pl_addr_q, pl_addr_d;

  logic                 accept;
  logic                 load_entry;
  logic                 is_comp;
  logic                 col_first;
  logic [COLCNT_W-1:0]  col_prev;

  pl_comp_detect u_comp_detect (
    .w_nib   (w_data[7:4]),
    .is_comp (is_comp)
  );

  assign w_ready   = (state_q == ST_LOAD) && !abort;
  assign accept    = w_valid && w_ready;
  assign col_first = ((beat_q % COL_LEN) == '0);
  // Compensation count already seen in the current column, before this beat.
  assign col_prev  = col_first ? '0 : col_comp_q;

  // Next-state logic: sequencing of a tile load and its cancellation.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    load_entry = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          load_entry = 1'b1;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (accept && (beat_q == LAST_BEAT)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        if (start) begin
          state_d    = ST_LOAD;
          load_entry = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: write forwarding, beat counting and compensation bookkeeping.
  always_comb begin
    beat_d      = beat_q;
    col_comp_d  = col_comp_q;
    comp_cnt_d  = comp_cnt_q;
    comp_ovf_d  = comp_ovf_q;
    pl_we_d     = accept;
    pl_weight_d = pl_weight_q;
    pl_addr_d   = pl_addr_q;

    if (accept) begin
      pl_weight_d = w_data;
      pl_addr_d   = beat_q;
      beat_d      = beat_q + 1'b1;
      col_comp_d  = col_prev;
      if (is_comp) begin
        col_comp_d = col_prev + 1'b1;
        if (comp_cnt_q != CNT_SAT) begin
          comp_cnt_d = comp_cnt_q + 1'b1;
        end
        if (col_prev == COL_LIMIT) begin
          comp_ovf_d = 1'b1;
        end
      end
    end

    // A new tile starts with clean counters; accept cannot coincide with this.
    if (load_entry) begin
      beat_d     = '0;
      col_comp_d = '0;
      comp_cnt_d = '0;
      comp_ovf_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      col_comp_q  <= '0;
      comp_cnt_q  <= '0;
      comp_ovf_q  <= 1'b0;
      pl_we_q     <= 1'b0;
      pl_weight_q <= '0;
      pl_addr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      beat_q      <= beat_d;
      col_comp_q  <= col_comp_d;
      comp_cnt_q  <= comp_cnt_d;
      comp_ovf_q  <= comp_ovf_d;
      pl_we_q     <= pl_we_d;
      pl_weight_q <= pl_weight_d;
      pl_addr_q   <= pl_addr_d;
    end
  end

  assign pl_we     = pl_we_q;
  assign pl_weight = pl_weight_q;
  assign pl_addr   = pl_addr_q;
  assign comp_cnt  = comp_cnt_q;
  assign comp_ovf  = comp_ovf_q;
  assign pl_done   = (state_q == ST_DONE);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_pre_load_ctrl.sv
// Self-checking bench for pre_load_ctrl: a cycle table for the basic
// handshake followed by whole-tile sequences for the multi-cycle cases.
module tb_pre_load_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       w_valid;
  logic [7:0] w_data;
  logic       w_ready;
  logic [7:0] pl_weight;
  logic [5:0] pl_addr;
  logic       pl_we;
  logic       pl_done;
  logic       busy;
  logic [4:0] comp_cnt;
  logic       comp_ovf;

  pre_load_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .w_valid   (w_valid),
    .w_data    (w_data),
    .w_ready   (w_ready),
    .pl_weight (pl_weight),
    .pl_addr   (pl_addr),
    .pl_we     (pl_we),
    .pl_done   (pl_done),
    .busy      (busy),
    .comp_cnt  (comp_cnt),
    .comp_ovf  (comp_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       abort;
    logic       w_valid;
    logic [7:0] w_data;
    logic       e_ready;
    logic       e_we;
    logic [5:0] e_addr;
    logic [7:0] e_weight;
    logic [4:0] e_cnt;
    logic       e_ovf;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t       tv [9];
  logic [7:0] tile [64];
  logic [5:0] wr_addr [$];
  logic [7:0] wr_data [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  // Record every write strobe seen by the pre-load unit.
  always @(negedge clk) begin
    if (pl_we === 1'b1) begin
      wr_addr.push_back(pl_addr);
      wr_data.push_back(pl_weight);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge in IDLE/DONE; returns at the first negedge in LOAD.
  task automatic start_load();
    wr_addr.delete();
    wr_data.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents tile[first..last]; returns at the negedge after the last accept.
  task automatic drive_beats(input int first, input int last, input bit gap);
    for (int i = first; i <= last; i++) begin
      if (gap) begin
        w_valid = 1'b0;
        @(negedge clk);
      end
      w_valid = 1'b1;
      w_data  = tile[i];
      @(negedge clk);
    end
    w_valid = 1'b0;
  endtask

  // Drain/done timing plus the full write log against tile[].
  task automatic finish_tile(input string name, input logic [4:0] exp_cnt, input logic exp_ovf);
    #1;
    check({name, "_drain_we"},   pl_we,   1'b1);
    check({name, "_drain_addr"}, pl_addr, 6'd63);
    check({name, "_drain_done"}, pl_done, 1'b0);
    @(negedge clk);
    #1;
    check({name, "_done"},      pl_done,  1'b1);
    check({name, "_busy"},      busy,     1'b0);
    check({name, "_we_idle"},   pl_we,    1'b0);
    check({name, "_comp_cnt"},  comp_cnt, exp_cnt);
    check({name, "_comp_ovf"},  comp_ovf, exp_ovf);
    check({name, "_wr_count"},  wr_addr.size(), 64);
    if (wr_addr.size() == 64) begin
      for (int i = 0; i < 64; i++) begin
        check($sformatf("%s_addr%0d", name, i), wr_addr[i], i);
        check($sformatf("%s_data%0d", name, i), wr_data[i], tile[i]);
      end
    end
  endtask

  initial begin
    // start, abort, valid, data | ready, we, addr, weight, cnt, ovf, busy, done
    tv[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
    tv[2] = '{1'b0, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 6'd0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0};
    tv[3] = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 6'd0, 8'h0F, 5'd0, 1'b0, 1'b1, 1'b0};
    tv[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 6'd1, 8'h33, 5'd1, 1'b0, 1'b1, 1'b0};
    tv[5] = '{1'b0, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0, 6'd1, 8'h33, 5'd1, 1'b0, 1'b1, 1'b0};
    tv[6] = '{1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 6'd2, 8'hF0, 5'd1, 1'b0, 1'b1, 1'b0};
    tv[7] = '{1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 6'd2, 8'hF0, 5'd1, 1'b0, 1'b0, 1'b0};
    tv[8] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 6'd2, 8'hF0, 5'd1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; w_valid = 1'b0; w_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_we",     pl_we,     1'b0);
    check("rst_addr",   pl_addr,   6'd0);
    check("rst_weight", pl_weight, 8'h00);
    check("rst_busy",   busy,      1'b0);
    check("rst_done",   pl_done,   1'b0);
    check("rst_cnt",    comp_cnt,  5'd0);
    check("rst_ovf",    comp_ovf,  1'b0);
    check("rst_ready",  w_ready,   1'b0);
    rst_n = 1'b1;

    // Cycle table: handshake, gap, start ignored in LOAD, abort, abort in IDLE.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      start = tv[k].start; abort = tv[k].abort;
      w_valid = tv[k].w_valid; w_data = tv[k].w_data;
      #1;
      check($sformatf("tv%0d_ready", k),  w_ready,   tv[k].e_ready);
      check($sformatf("tv%0d_we", k),     pl_we,     tv[k].e_we);
      check($sformatf("tv%0d_addr", k),   pl_addr,   tv[k].e_addr);
      check($sformatf("tv%0d_weight", k), pl_weight, tv[k].e_weight);
      check($sformatf("tv%0d_cnt", k),    comp_cnt,  tv[k].e_cnt);
      check($sformatf("tv%0d_ovf", k),    comp_ovf,  tv[k].e_ovf);
      check($sformatf("tv%0d_busy", k),   busy,      tv[k].e_busy);
      check($sformatf("tv%0d_done", k),   pl_done,   tv[k].e_done);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; w_valid = 1'b0;

    // Plain tile of in-range weights, continuous beats.
    for (int i = 0; i < 64; i++) tile[i] = 8'h0F;
    start_load();
    drive_beats(0, 63, 1'b0);
    finish_tile("plain", 5'd0, 1'b0);

    // One out-of-range weight per column, restarted from DONE.
    for (int i = 0; i < 64; i++) begin
      tile[i] = 8'h0F;
      if ((i % 8) == ((2 * (i / 8)) % 8)) tile[i] = ((i / 8) % 2 == 0) ? 8'd51 : 8'hC9;
    end
    start_load();
    drive_beats(0, 63, 1'b0);
    finish_tile("percol", 5'd8, 1'b0);
    @(negedge clk);
    #1;
    check("percol_hold_cnt",  comp_cnt, 5'd8);
    check("percol_hold_done", pl_done,  1'b1);

    // Four compensation weights in column 0.
    for (int i = 0; i < 64; i++) tile[i] = (i < 4) ? 8'h33 : 8'h0F;
    start_load();
    drive_beats(0, 2, 1'b0);
    #1;
    check("col0_cnt3", comp_cnt, 5'd3);
    check("col0_ovf3", comp_ovf, 1'b0);
    drive_beats(3, 3, 1'b0);
    #1;
    check("col0_cnt4", comp_cnt, 5'd4);
    check("col0_ovf4", comp_ovf, 1'b1);
    drive_beats(4, 63, 1'b0);
    finish_tile("col0", 5'd4, 1'b1);

    // Every weight out of range: count saturates.
    for (int i = 0; i < 64; i++) tile[i] = 8'h80;
    start_load();
    drive_beats(0, 63, 1'b0);
    finish_tile("sat", 5'd24, 1'b1);

    // Valid toggling every other cycle, distinct in-range weights.
    for (int i = 0; i < 64; i++) tile[i] = (i % 2 == 1) ? (8'hF0 | 8'(i % 16)) : 8'(i % 16);
    start_load();
    drive_beats(0, 63, 1'b1);
    finish_tile("gap", 5'd0, 1'b0);

    // Abort presented together with beat 20.
    start_load();
    drive_beats(0, 19, 1'b0);
    w_valid = 1'b1; w_data = tile[20]; abort = 1'b1;
    #1;
    check("abort_ready",   w_ready, 1'b0);
    check("abort_pend_we", pl_we,   1'b1);
    check("abort_pend_ad", pl_addr, 6'd19);
    @(negedge clk);
    abort = 1'b0; w_valid = 1'b0;
    #1;
    check("abort_busy",  busy,    1'b0);
    check("abort_done",  pl_done, 1'b0);
    check("abort_we",    pl_we,   1'b0);
    check("abort_count", wr_addr.size(), 20);
    start_load();
    drive_beats(0, 63, 1'b0);
    finish_tile("reload", 5'd0, 1'b0);

    // Reset pulse at beat 30.
    for (int i = 0; i < 64; i++) tile[i] = 8'h33;
    start_load();
    drive_beats(0, 29, 1'b0);
    w_valid = 1'b1; w_data = tile[30];
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_we",     pl_we,     1'b0);
    check("mrst_addr",   pl_addr,   6'd0);
    check("mrst_weight", pl_weight, 8'h00);
    check("mrst_busy",   busy,      1'b0);
    check("mrst_cnt",    comp_cnt,  5'd0);
    check("mrst_ovf",    comp_ovf,  1'b0);
    check("mrst_ready",  w_ready,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    repeat (4) @(negedge clk);
    #1;
    check("post_rst_writes", wr_addr.size(), 0);
    check("post_rst_busy",   busy,           1'b0);
    check("post_rst_done",   pl_done,        1'b0);
    w_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
